dpram_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sits directly in front of the 8-entry dual-port RAM. It drives port A as the write side and port B as the read side. The block turns push/pop requests into RAM addresses and write strobes. It tracks the RAM's two-cycle registered-address read latency, and it protects slots that have an in-flight read from being overwritten. Downstream logic gets a valid-qualified data stream.

---
 rtl/dpram_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dpram_fifo_ctrl: FIFO controller for an 8-entry 2-cycle-latency DPRAM.   |
// | Optional macro DPRAM_FIFO_OUTREG_EN registers pop_data/pop_valid.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dpram_fifo_ctrl #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  output logic          o_full,
  input  logic          i_pop,
  output logic          o_empty,
  output logic          o_pop_valid,
  output logic [DW-1:0] o_pop_data,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic          o_underflow,
  output logic [7:0]    o_ram_addra,
  output logic [DW-1:0] o_ram_dina,
  output logic          o_ram_wea,
  output logic [7:0]    o_ram_addrb,
  output logic          o_ram_web,
  input  logic [DW-1:0] i_ram_doutb
);

  localparam logic [AW:0]   c_DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   c_ZERO    = '0;
  localparam logic [AW-1:0] c_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   r_occ;
  logic [1:0]    r_vp;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW:0]   w_push_inc;
  logic [AW:0]   w_retire_dec;
  logic [AW:0]   w_count_nxt;

  assign o_full  = (r_occ == c_DEPTH);
  assign o_empty = (r_count == c_ZERO);

  assign w_push_ok    = i_push && !o_full;
  assign w_pop_ok     = i_pop && !o_empty;
  assign w_push_inc   = {{AW{1'b0}}, w_push_ok};
  assign w_retire_dec = {{AW{1'b0}}, r_vp[0]};

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // occ keeps a popped slot reserved until its data has left the RAM array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_occ       <= '0;
      r_vp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_count     <= w_count_nxt;
      r_occ       <= r_occ + w_push_inc - w_retire_dec;
      r_vp        <= {r_vp[0], w_pop_ok};
      r_overflow  <= i_push && o_full;
      r_underflow <= i_pop && o_empty;
    end
  end

  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

  assign o_ram_addra = {{(8-AW){1'b0}}, r_wr_ptr};
  assign o_ram_dina  = i_push_data;
  assign o_ram_wea   = w_push_ok && rst_n;
  assign o_ram_addrb = {{(8-AW){1'b0}}, r_rd_ptr};
  assign o_ram_web   = 1'b0;

`ifdef DPRAM_FIFO_OUTREG_EN
  logic          r_pop_valid;
  logic [DW-1:0] r_pop_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
    end else begin
      r_pop_valid <= r_vp[1];
      r_pop_data  <= i_ram_doutb;
    end
  end

  assign o_pop_valid = r_pop_valid;
  assign o_pop_data  = r_pop_data;
`else
  assign o_pop_valid = r_vp[1];
  assign o_pop_data  = i_ram_doutb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dpram_fifo_ctrl: directed + random bench with a queue-based model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dpram_fifo_ctrl;

`ifdef DPRAM_FIFO_OUTREG_EN
  localparam int c_LAT = 3;
`else
  localparam int c_LAT = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic       i_push;
  logic [7:0] i_push_data;
  logic       i_pop;
  logic       o_full;
  logic       o_empty;
  logic       o_pop_valid;
  logic [7:0] o_pop_data;
  logic [3:0] o_count;
  logic       o_overflow;
  logic       o_underflow;
  logic [7:0] o_ram_addra;
  logic [7:0] o_ram_dina;
  logic       o_ram_wea;
  logic [7:0] o_ram_addrb;
  logic       o_ram_web;
  logic [7:0] r_ram_doutb;

  dpram_fifo_ctrl #(.AW(3), .DW(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (i_push),
    .i_push_data (i_push_data),
    .o_full      (o_full),
    .i_pop       (i_pop),
    .o_empty     (o_empty),
    .o_pop_valid (o_pop_valid),
    .o_pop_data  (o_pop_data),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
    .o_ram_addra (o_ram_addra),
    .o_ram_dina  (o_ram_dina),
    .o_ram_wea   (o_ram_wea),
    .o_ram_addrb (o_ram_addrb),
    .o_ram_web   (o_ram_web),
    .i_ram_doutb (r_ram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DPRAM with registered read address and registered output: 2-cycle read.
  logic [7:0] r_mem [8];
  logic [2:0] r_addrb_q;
  always @(posedge clk) begin
    if (o_ram_wea) r_mem[o_ram_addra[2:0]] <= o_ram_dina;
    r_addrb_q   <= o_ram_addrb[2:0];
    r_ram_doutb <= r_mem[r_addrb_q];
  end

  typedef struct {
    int         due;
    logic [7:0] d;
  } pend_t;

  logic [7:0] m_q[$];
  pend_t      m_pend[$];
  int         m_cyc;
  int         m_wcnt;
  int         m_rcnt;
  bit         m_prev_pop;
  bit         m_ovf;
  bit         m_udf;
  int         n_vec;
  int         n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend.delete();
    m_wcnt     = 0;
    m_rcnt     = 0;
    m_prev_pop = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  // One clock cycle: drive, check everything visible this cycle, advance model.
  task automatic step(input bit p, input logic [7:0] d, input bit q);
    int  sz;
    bit  mfull;
    bit  ev;
    sz    = m_q.size();
    mfull = ((sz + int'(m_prev_pop)) == 8);
    ev    = (m_pend.size() != 0) && (m_pend[0].due == m_cyc);
    i_push      = p;
    i_push_data = d;
    i_pop       = q;
    #1;
    chk("count", 32'(o_count), 32'(sz));
    chk("empty", 32'(o_empty), 32'(sz == 0));
    chk("full", 32'(o_full), 32'(mfull));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("underflow", 32'(o_underflow), 32'(m_udf));
    chk("pop_valid", 32'(o_pop_valid), 32'(ev));
    if (ev) chk("pop_data", 32'(o_pop_data), 32'(m_pend[0].d));
    chk("ram_wea", 32'(o_ram_wea), 32'(p && !mfull));
    chk("ram_addra", 32'(o_ram_addra), 32'(m_wcnt % 8));
    chk("ram_addrb", 32'(o_ram_addrb), 32'(m_rcnt % 8));
    chk("ram_dina", 32'(o_ram_dina), 32'(d));
    chk("ram_web", 32'(o_ram_web), 32'd0);
    @(posedge clk);
    if (ev) void'(m_pend.pop_front());
    m_ovf      = p && mfull;
    m_udf      = q && (sz == 0);
    m_prev_pop = q && (sz != 0);
    if (m_prev_pop) begin
      m_pend.push_back('{due: m_cyc + c_LAT, d: m_q.pop_front()});
      m_rcnt++;
    end
    if (p && !mfull) begin
      m_q.push_back(d);
      m_wcnt++;
    end
    m_cyc++;
    #1;
  endtask

  task automatic do_reset();
    i_push      = 1'b1;
    i_push_data = 8'h5A;
    i_pop       = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("rst_pop_valid", 32'(o_pop_valid), 32'd0);
    chk("rst_ram_wea", 32'(o_ram_wea), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_underflow", 32'(o_underflow), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    i_push = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    m_cyc  = 0;
    rst_n  = 1'b0;
    do_reset();

    // Fill, refuse a 9th push, free one slot and refill it at index 0.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i * 8'h11), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("refill_addra", 32'(o_ram_addra), 32'd0);
    step(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);

    // Pop on empty, then push+pop together on empty.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);

    // Streaming one-in/one-out across pointer wrap.
    step(1'b1, 8'h00, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);

    // Reset with two reads in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);

    // Random traffic in several push/pop bias phases.
    for (int ph = 0; ph < 4; ph++) begin
      int pp;
      int pq;
      pp = (ph == 0) ? 70 : (ph == 1) ? 30 : (ph == 2) ? 95 : 50;
      pq = (ph == 0) ? 30 : (ph == 1) ? 70 : (ph == 2) ? 90 : 50;
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < pp, 8'($urandom), $urandom_range(0, 99) < pq);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
